// File: rtl/branch_resolve_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_pkg
//  Description : Shared definitions for the branch resolution block:
//                EX control-transfer class encoding and the sequential
//                instruction step.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_pkg;

    // EX instruction class as presented on ex_br_type
    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_COND = 2'b01,
        BR_JAL  = 2'b10,
        BR_JALR = 2'b11
    } br_type_e;

    // Fall-through distance between consecutive instructions
    localparam int PC_STEP = 4;

endpackage : branch_resolve_pkg
`default_nettype wire

// File: rtl/branch_resolve_pred_shadow_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pred_shadow_stage
//  Description : One stage of the prediction shadow pipeline. Holds the
//                {valid, pc, pred, target} record for the instruction that
//                occupies the matching core stage.
//                Edge priority: reset > flush > stall > advance.
//  Ports       : clk, rst (sync, active-low)
//                i_stall, i_flush          - pipeline control
//                i_valid/i_pc/i_pred/i_target - record from previous stage
//                o_valid/o_pc/o_pred/o_target - record held by this stage
//  Revision    : 1.0 - initial release
// ============================================================================
module pred_shadow_stage #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_valid,
    input  logic [PC_W-1:0] i_pc,
    input  logic [1:0]      i_pred,
    input  logic [PC_W-1:0] i_target,
    output logic            o_valid,
    output logic [PC_W-1:0] o_pc,
    output logic [1:0]      o_pred,
    output logic [PC_W-1:0] o_target
);

    logic            r_valid;
    logic [PC_W-1:0] r_pc;
    logic [1:0]      r_pred;
    logic [PC_W-1:0] r_target;

    // Only the valid bit needs clearing; payload is don't-care when invalid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (!i_stall) begin
            r_valid <= i_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_stall) begin
            r_pc     <= i_pc;
            r_pred   <= i_pred;
            r_target <= i_target;
        end
    end

    assign o_valid  = r_valid;
    assign o_pc     = r_pc;
    assign o_pred   = r_pred;
    assign o_target = r_target;

endmodule : pred_shadow_stage
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve
//  Description : Tracks the fetch-time prediction of each instruction down to
//                EX, compares predicted and actual next PC, raises a same-cycle
//                redirect on mispredict, emits a registered one-cycle
//                predictor update and keeps saturating statistics counters.
//  Ports       : clk, rst (sync, active-low)
//                if_valid, if_pc, if_pred, if_pred_target - fetch slot
//                stall, flush_ext                         - core control
//                ex_br_type, ex_taken, ex_target          - EX resolution
//                redirect, redirect_pc                    - refetch request
//                upd_w_en, upd_br_in, upd_pc, upd_target  - predictor write
//                br_cnt, miss_cnt                         - statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [PC_W-1:0]  if_pc,
    input  logic [1:0]       if_pred,
    input  logic [PC_W-1:0]  if_pred_target,
    input  logic             stall,
    input  logic             flush_ext,
    input  logic [1:0]       ex_br_type,
    input  logic             ex_taken,
    input  logic [PC_W-1:0]  ex_target,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [1:0]       upd_w_en,
    output logic             upd_br_in,
    output logic [PC_W-1:0]  upd_pc,
    output logic [PC_W-1:0]  upd_target,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam logic [PC_W-1:0] c_pc_step = PC_W'(PC_STEP);

    // ------------------------------------------------------------------
    // Shadow pipeline IF -> ID -> EX
    // ------------------------------------------------------------------
    logic            w_id_valid, w_ex_valid;
    logic [PC_W-1:0] w_id_pc, w_ex_pc;
    logic [1:0]      w_id_pred, w_ex_pred;
    logic [PC_W-1:0] w_id_target, w_ex_target_pred;
    logic            w_flush;
    logic            w_redirect;

    assign w_flush = w_redirect | flush_ext;

    pred_shadow_stage #(.PC_W(PC_W)) u_id_stage (
        .clk      (clk),
        .rst      (rst),
        .i_stall  (stall),
        .i_flush  (w_flush),
        .i_valid  (if_valid),
        .i_pc     (if_pc),
        .i_pred   (if_pred),
        .i_target (if_pred_target),
        .o_valid  (w_id_valid),
        .o_pc     (w_id_pc),
        .o_pred   (w_id_pred),
        .o_target (w_id_target)
    );

    pred_shadow_stage #(.PC_W(PC_W)) u_ex_stage (
        .clk      (clk),
        .rst      (rst),
        .i_stall  (stall),
        .i_flush  (w_flush),
        .i_valid  (w_id_valid),
        .i_pc     (w_id_pc),
        .i_pred   (w_id_pred),
        .i_target (w_id_target),
        .o_valid  (w_ex_valid),
        .o_pc     (w_ex_pc),
        .o_pred   (w_ex_pred),
        .o_target (w_ex_target_pred)
    );

    // ------------------------------------------------------------------
    // Resolution
    // ------------------------------------------------------------------
    br_type_e        w_type;
    logic            w_ex_fire;
    logic            w_fire;
    logic            w_taken;
    logic [PC_W-1:0] w_fall_pc;
    logic [PC_W-1:0] w_pred_next;
    logic [PC_W-1:0] w_act_next;
    logic            w_btb_we;

    assign w_type    = br_type_e'(ex_br_type);
    // The stall gate guarantees a single fire per EX instruction: the
    // instruction only fires on the cycle it leaves EX.
    assign w_ex_fire = w_ex_valid & ~stall & (w_type != BR_NONE);
    // An external flush or an active reset kills the resolution entirely.
    assign w_fire    = w_ex_fire & ~flush_ext & rst;

    assign w_taken     = (w_type == BR_COND) ? ex_taken : 1'b1;
    assign w_fall_pc   = w_ex_pc + c_pc_step;
    assign w_pred_next = (w_ex_pred[1] & w_ex_pred[0]) ? w_ex_target_pred : w_fall_pc;
    assign w_act_next  = w_taken ? ex_target : w_fall_pc;

    assign w_redirect  = w_fire & (w_pred_next != w_act_next);
    assign redirect    = w_redirect;
    assign redirect_pc = w_redirect ? w_act_next : '0;

    // BTB write: install/retarget on taken, invalidate a stale hit on not-taken.
    assign w_btb_we = w_taken ? (~w_ex_pred[0] | (w_ex_target_pred != ex_target))
                              : w_ex_pred[0];

    // ------------------------------------------------------------------
    // Registered predictor update
    // ------------------------------------------------------------------
    logic [1:0]      r_upd_w_en;
    logic            r_upd_br_in;
    logic [PC_W-1:0] r_upd_pc;
    logic [PC_W-1:0] r_upd_target;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_upd_w_en   <= 2'b00;
            r_upd_br_in  <= 1'b0;
            r_upd_pc     <= '0;
            r_upd_target <= '0;
        end else if (w_fire) begin
            r_upd_w_en   <= {(w_type == BR_COND), w_btb_we};
            r_upd_br_in  <= w_taken;
            r_upd_pc     <= w_ex_pc;
            r_upd_target <= ex_target;
        end else begin
            r_upd_w_en   <= 2'b00;
        end
    end

    assign upd_w_en   = r_upd_w_en;
    assign upd_br_in  = r_upd_br_in;
    assign upd_pc     = r_upd_pc;
    assign upd_target = r_upd_target;

    // ------------------------------------------------------------------
    // Saturating statistics
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_br_cnt   <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_fire && (r_br_cnt != '1)) begin
                r_br_cnt <= r_br_cnt + 1'b1;
            end
            if (w_redirect && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign br_cnt   = r_br_cnt;
    assign miss_cnt = r_miss_cnt;

endmodule : branch_resolve
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve
//  Description : Directed self-checking bench for branch_resolve.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve;

    localparam int PC_W  = 32;
    localparam int CNT_W = 32;

    logic             clk;
    logic             rst;
    logic             if_valid;
    logic [PC_W-1:0]  if_pc;
    logic [1:0]       if_pred;
    logic [PC_W-1:0]  if_pred_target;
    logic             stall;
    logic             flush_ext;
    logic [1:0]       ex_br_type;
    logic             ex_taken;
    logic [PC_W-1:0]  ex_target;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic [1:0]       upd_w_en;
    logic             upd_br_in;
    logic [PC_W-1:0]  upd_pc;
    logic [PC_W-1:0]  upd_target;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] miss_cnt;

    int n_cmp;
    int n_bad;

    branch_resolve #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_pred        (if_pred),
        .if_pred_target (if_pred_target),
        .stall          (stall),
        .flush_ext      (flush_ext),
        .ex_br_type     (ex_br_type),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .upd_w_en       (upd_w_en),
        .upd_br_in      (upd_br_in),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .br_cnt         (br_cnt),
        .miss_cnt       (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Send one instruction through IF and ID so it sits in EX.
    task automatic to_ex(input logic [PC_W-1:0] pc, input logic [1:0] pred,
                         input logic [PC_W-1:0] tgt);
        if_valid = 1'b1; if_pc = pc; if_pred = pred; if_pred_target = tgt;
        step();
        if_valid = 1'b0;
        step();
    endtask

    task automatic set_ex(input logic [1:0] ty, input logic tk, input logic [PC_W-1:0] tgt);
        ex_br_type = ty; ex_taken = tk; ex_target = tgt;
        settle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0; if_valid = 1'b0; if_pc = '0; if_pred = 2'b00; if_pred_target = '0;
        stall = 1'b0; flush_ext = 1'b0; ex_br_type = 2'b00; ex_taken = 1'b0; ex_target = '0;
        step(); step();

        // Reset state
        chk("rst_upd_w_en", 64'(upd_w_en), 64'h0);
        chk("rst_upd_pc",   64'(upd_pc),   64'h0);
        chk("rst_br_cnt",   64'(br_cnt),   64'h0);
        chk("rst_miss_cnt", 64'(miss_cnt), 64'h0);
        chk("rst_redirect", 64'(redirect), 64'h0);
        rst = 1'b1;
        step();

        // Correctly predicted taken conditional
        to_ex(32'h100, 2'b11, 32'h200);
        set_ex(2'b01, 1'b1, 32'h200);
        chk("s1_redirect",    64'(redirect),    64'h0);
        chk("s1_redirect_pc", 64'(redirect_pc), 64'h0);
        step();
        set_ex(2'b00, 1'b0, 32'h0);
        chk("s1_upd_w_en",  64'(upd_w_en),  64'h2);
        chk("s1_upd_br_in", 64'(upd_br_in), 64'h1);
        chk("s1_upd_pc",    64'(upd_pc),    64'h100);
        chk("s1_br_cnt",    64'(br_cnt),    64'h1);
        chk("s1_miss_cnt",  64'(miss_cnt),  64'h0);
        step();
        chk("s1_pulse_end", 64'(upd_w_en),  64'h0);

        // Predicted not-taken, actually taken; follower sits in ID
        if_valid = 1'b1; if_pc = 32'h100; if_pred = 2'b00; if_pred_target = 32'h0;
        step();
        if_pc = 32'h104;
        step();
        if_valid = 1'b0;
        set_ex(2'b01, 1'b1, 32'h180);
        chk("s2_redirect",    64'(redirect),    64'h1);
        chk("s2_redirect_pc", 64'(redirect_pc), 64'h180);
        step();
        settle();
        chk("s2_upd_w_en",     64'(upd_w_en),   64'h3);
        chk("s2_upd_br_in",    64'(upd_br_in),  64'h1);
        chk("s2_upd_target",   64'(upd_target), 64'h180);
        chk("s2_miss_cnt",     64'(miss_cnt),   64'h1);
        chk("s2_follower_dead",64'(redirect),   64'h0);
        step();
        chk("s2_br_cnt_hold",  64'(br_cnt),     64'h2);
        chk("s2_no_pulse",     64'(upd_w_en),   64'h0);
        set_ex(2'b00, 1'b0, 32'h0);

        // Predicted taken, actually not taken
        to_ex(32'h100, 2'b11, 32'h200);
        set_ex(2'b01, 1'b0, 32'h0);
        chk("s3_redirect_pc", 64'(redirect_pc), 64'h104);
        step();
        set_ex(2'b00, 1'b0, 32'h0);
        chk("s3_upd_w_en",  64'(upd_w_en),  64'h3);
        chk("s3_upd_br_in", 64'(upd_br_in), 64'h0);
        chk("s3_miss_cnt",  64'(miss_cnt),  64'h2);

        // jalr with a stale BTB target
        to_ex(32'h40, 2'b11, 32'h80);
        set_ex(2'b11, 1'b0, 32'h90);
        chk("s4_redirect_pc", 64'(redirect_pc), 64'h90);
        step();
        set_ex(2'b00, 1'b0, 32'h0);
        chk("s4_upd_w_en",  64'(upd_w_en),   64'h1);
        chk("s4_upd_pc",    64'(upd_pc),     64'h40);
        chk("s4_upd_tgt",   64'(upd_target), 64'h90);
        chk("s4_miss_cnt",  64'(miss_cnt),   64'h3);
        chk("s4_br_cnt",    64'(br_cnt),     64'h4);

        // Branch held in EX under a 3-cycle stall
        to_ex(32'h300, 2'b11, 32'h380);
        stall = 1'b1;
        set_ex(2'b01, 1'b1, 32'h380);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s5_stall_no_upd", 64'(upd_w_en), 64'h0);
        end
        chk("s5_stall_br_cnt", 64'(br_cnt), 64'h4);
        stall = 1'b0;
        step();
        chk("s5_upd_w_en", 64'(upd_w_en), 64'h2);
        chk("s5_br_cnt",   64'(br_cnt),   64'h5);
        step();
        chk("s5_single",   64'(upd_w_en), 64'h0);
        chk("s5_br_hold",  64'(br_cnt),   64'h5);
        set_ex(2'b00, 1'b0, 32'h0);

        // External flush coincident with a would-be mispredict
        to_ex(32'h500, 2'b00, 32'h0);
        flush_ext = 1'b1;
        set_ex(2'b01, 1'b1, 32'h580);
        chk("s6_redirect", 64'(redirect), 64'h0);
        step();
        flush_ext = 1'b0;
        settle();
        chk("s6_upd_w_en", 64'(upd_w_en), 64'h0);
        chk("s6_br_cnt",   64'(br_cnt),   64'h5);
        chk("s6_killed",   64'(redirect), 64'h0);
        set_ex(2'b00, 1'b0, 32'h0);

        // jal: BTB hit but predicted not-taken, target already correct
        to_ex(32'h600, 2'b01, 32'h640);
        set_ex(2'b10, 1'b0, 32'h640);
        chk("s7_redirect_pc", 64'(redirect_pc), 64'h640);
        step();
        set_ex(2'b00, 1'b0, 32'h0);
        chk("s7_upd_w_en", 64'(upd_w_en), 64'h0);
        chk("s7_br_cnt",   64'(br_cnt),   64'h6);
        chk("s7_miss_cnt", 64'(miss_cnt), 64'h4);

        // Wrap at top of address space, then reset right after the mispredict
        to_ex(32'hFFFF_FFFC, 2'b11, 32'h10);
        set_ex(2'b01, 1'b0, 32'h0);
        chk("s8_redirect",    64'(redirect),    64'h1);
        chk("s8_redirect_pc", 64'(redirect_pc), 64'h0);
        step();
        set_ex(2'b00, 1'b0, 32'h0);
        chk("s8_upd_w_en", 64'(upd_w_en), 64'h3);
        chk("s8_miss_cnt", 64'(miss_cnt), 64'h5);
        rst = 1'b0;
        step();
        chk("s8_rst_upd",  64'(upd_w_en), 64'h0);
        chk("s8_rst_br",   64'(br_cnt),   64'h0);
        chk("s8_rst_miss", 64'(miss_cnt), 64'h0);
        rst = 1'b1;
        step();
        chk("s8_post_upd", 64'(upd_w_en), 64'h0);
        chk("s8_post_br",  64'(br_cnt),   64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_branch_resolve
`default_nettype wire

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter PC_W, default 32, PC width in bits.
REQ-002 Parameter CNT_W, default 32, statistics counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; the only reset is synchronous, active-low.
REQ-005 if_valid  in  1  fetch slot holds a real instruction.
REQ-006 if_pc  in  PC_W  fetch PC.
REQ-007 if_pred  in  2  predictor output: bit1 = predicted taken, bit0 = BTB hit.
REQ-008 if_pred_target  in  PC_W  predictor target.
REQ-009 stall  in  1  core pipeline stall; holds ID and EX shadow stages.
REQ-010 flush_ext  in  1  external flush, e.g. trap; kills ID and EX shadow stages.
REQ-011 ex_br_type  in  2  EX instruction class: 00 none, 01 conditional, 10 jal, 11 jalr.
REQ-012 ex_taken  in  1  EX conditional outcome; ignored unless type 01.
REQ-013 ex_target  in  PC_W  EX resolved branch/jump target.
REQ-014 redirect  out  1  mispredict; the core kills IF/ID and refetches.
REQ-015 redirect_pc  out  PC_W  correct next PC when redirect is 1.
REQ-016 upd_w_en  out  2  predictor write enables: bit0 = BTB, bit1 = 2-bit counter.
REQ-017 upd_br_in  out  1  actual taken for the predictor update.
REQ-018 upd_pc, upd_target  out  PC_W each  predictor write PC and target.
REQ-019 br_cnt, miss_cnt  out  CNT_W each  resolved control-transfer count and mispredict count.

Function
REQ-020 Internal shadow pipeline carries {valid, pc, pred, target} IF->ID->EX in step with the core.
REQ-021 Per-edge priority for each shadow stage: reset > (redirect | flush_ext) > stall > advance.
- Flush clears the valid bit of both stages.
- Stall holds both stages.
- Advance loads ID from IF and EX from ID.
REQ-022 ex_fire = ex_valid & ~stall & ex_br_type != 00; at most one resolution per EX instruction, even under multi-cycle stall.
REQ-023 Actual taken: type 01 uses ex_taken; types 10 and 11 are always 1.
REQ-024 Next-PC arithmetic is PC_W bits wide, modulo 2^PC_W; +4 wraps at the top of the address space.
- Predicted next = (pred[1] & pred[0]) ? pred_target : pc+4.
- Actual next = taken ? ex_target : pc+4.
REQ-025 Mispredict = ex_fire & (predicted next != actual next).
- redirect is combinational in the same cycle.
- redirect_pc = actual next; redirect_pc is 0 when redirect is 0.
REQ-026 Predictor update outputs are registered, one cycle after ex_fire, and pulse for exactly one cycle.
REQ-027 upd_w_en[1] = 1 for every fired type-01 instruction.
REQ-028 upd_w_en[0] = 1 in either case:
- taken and (pred[0] = 0 or pred_target != ex_target);
- not taken and pred[0] = 1 (clears the BTB entry).
REQ-029 upd_br_in = actual taken; upd_pc = EX pc; upd_target = ex_target.
REQ-030 br_cnt increments on each ex_fire.
REQ-031 miss_cnt increments on each mispredict.
REQ-032 Both counters saturate at all-ones.
REQ-033 flush_ext in the same cycle as ex_fire suppresses redirect, the update and both counter increments.
REQ-034 A redirect in cycle N invalidates the ID/EX shadow entries, so no wrong-path instruction fires in cycle N+1.

Reset
REQ-035 While rst = 0 at an edge, all of the following are cleared:
- shadow valid bits, upd_w_en, upd_br_in, upd_pc, upd_target, br_cnt, miss_cnt.
REQ-036 Reset asserted mid-operation discards any pending update; no update pulse appears in the cycle after reset release.

Structure
REQ-037 A shared package holds the br_type encoding (BR_NONE, BR_COND, BR_JAL, BR_JALR) and the PC_STEP = 4 constant.
REQ-038 One sub-module, pred_shadow_stage, is instantiated twice (ID, EX); it contains valid/payload registers with stall and flush inputs.

Verification
REQ-039 Scenario: pc 0x100, pred 2'b11, target 0x200; EX type 01, taken = 1, target 0x200.
- Response: redirect 0; upd_w_en = 2'b10 the next cycle; br_cnt +1; miss_cnt +0.
REQ-040 Scenario: pc 0x100, pred 2'b00; EX type 01, taken = 1, target 0x180.
- Response: redirect 1, redirect_pc 0x180; next cycle upd_w_en = 2'b11, upd_br_in 1.
- The instruction following in ID never fires.
REQ-041 Scenario: pc 0x100, pred 2'b11, target 0x200; EX type 01, taken = 0.
- Response: redirect_pc 0x104; upd_w_en = 2'b11, upd_br_in 0.
REQ-042 Scenario: jalr at 0x40, pred 2'b11, target 0x80; actual ex_target 0x90.
- Response: redirect_pc 0x90; upd_w_en = 2'b01; miss_cnt +1.
REQ-043 Scenario: stall held 3 cycles with a branch in EX, then released.
- Response: exactly one update pulse; br_cnt +1.
REQ-044 Scenario: rst = 0 in the cycle after a mispredict; pc 0xFFFF_FFFC not-taken wraps.
- Response: no update pulse after reset; counters 0; the wrap case gives redirect_pc 0x0000_0000.
